fifo_write_arbiter: RTL and testbench

- Round-robin arbiter that shares the write port of async_fifo among NUM_SRC packet sources.
- Sits in the async_fifo write-clock domain and drives write_en/write_data directly.
- Holds each grant for a whole packet, ending at the last beat, so packets are never interleaved in the FIFO.
- Stalls every source on full; flags any packet longer than MAX_PKT beats.

---
 rtl/fifo_arb_pkg.sv | 23 ++
 rtl/fifo_write_arbiter_rr_pick.sv | 34 +++
 rtl/fifo_write_arbiter.sv | 115 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the packet-granular FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_SRC    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_PKT    = 16;

  // Ceiling log2, never below 1 so it can always size a vector.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int  NUM_SRC = DEF_NUM_SRC,
  localparam int IW      = clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               any,
  output logic [IW-1:0]      idx
);

  logic [2*NUM_SRC-1:0] dbl;
  logic [IW:0]          pos;

  assign dbl = {req, req};

  // Scan from the far end so the nearest requester to ptr is written last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    pos = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (dbl[pos]) begin
        any = 1'b1;
        if (pos >= (IW+1)'(NUM_SRC)) pos = pos - (IW+1)'(NUM_SRC);
        idx = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-granular arbiter sharing one FIFO write port among NUM_SRC sources.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int  NUM_SRC    = DEF_NUM_SRC,
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int  MAX_PKT    = DEF_MAX_PKT,
  localparam int SW         = clog2(NUM_SRC),
  localparam int CW         = clog2(MAX_PKT)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]            src_last,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic                          fifo_full,
  output logic                          fifo_write_en,
  output logic [DATA_WIDTH-1:0]         fifo_write_data,
  output logic [SW-1:0]                 grant_id,
  output logic                          busy,
  output logic [NUM_SRC-1:0]            overrun,
  input  logic                          overrun_clear
);

  arb_state_e                          state_q, state_d;
  logic [SW-1:0]                       rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]                       grant_q, grant_d;
  logic [CW-1:0]                       beat_cnt_q, beat_cnt_d;
  logic [NUM_SRC-1:0]                  overrun_q, overrun_d, ovr_set;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]  data_arr;
  logic                                pick_any;
  logic [SW-1:0]                       pick_idx;
  logic                                gnt_act, accept, cnt_max;
  logic [SW-1:0]                       next_ptr;

  assign data_arr = src_data;

  rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req (src_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign gnt_act  = (state_q == GRANT);
  assign accept   = gnt_act & src_valid[grant_q] & ~fifo_full;
  assign cnt_max  = (beat_cnt_q == CW'(MAX_PKT - 1));
  assign next_ptr = (grant_q == SW'(NUM_SRC - 1)) ? '0 : grant_q + SW'(1);

  // Write port is a straight mux of the granted source; data is zeroed when idle.
  always_comb begin
    src_ready       = '0;
    fifo_write_en   = 1'b0;
    fifo_write_data = '0;
    if (gnt_act) begin
      src_ready[grant_q] = ~fifo_full;
      fifo_write_en      = accept;
      if (accept) fifo_write_data = data_arr[grant_q];
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    ovr_set    = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          // A packet that hits MAX_PKT without last is cut; its tail re-arbitrates.
          if (src_last[grant_q] || cnt_max) begin
            ovr_set[grant_q] = ~src_last[grant_q];
            state_d          = IDLE;
            rr_ptr_d         = next_ptr;
            beat_cnt_d       = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Set beats clear on the same bit.
    overrun_d = (overrun_clear ? '0 : overrun_q) | ovr_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      overrun_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      overrun_q  <= overrun_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = gnt_act;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus random traffic against a packet-level model.
module tb_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MP = 16;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    src_valid = '0, src_last = '0, src_ready, overrun;
  logic [N*DW-1:0] src_data = '0;
  logic            fifo_full = 1'b0, overrun_clear = 1'b0, fifo_write_en, busy;
  logic [DW-1:0]   fifo_write_data;
  logic [1:0]      grant_id;

  fifo_write_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .MAX_PKT(MP)) dut (
    .clk(clk), .reset_n(reset_n), .src_valid(src_valid), .src_data(src_data),
    .src_last(src_last), .src_ready(src_ready), .fifo_full(fifo_full),
    .fifo_write_en(fifo_write_en), .fifo_write_data(fifo_write_data),
    .grant_id(grant_id), .busy(busy), .overrun(overrun), .overrun_clear(overrun_clear)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [8:0]   srcq [N][$];   // {last, data} per source
  logic [DW-1:0] wlog[$], exq[$];
  logic         c_full = 1'b0, c_clr = 1'b0, c_rst = 1'b0;
  logic [N-1:0] c_hold = '0;
  int           pushed = 0;

  // Packet-level reference: who owns the port, where the next search starts, beats so far.
  int           m_owner = -1, m_ptr = 0, m_gid = 0, m_cnt = 0;
  logic [N-1:0] m_ovr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input int s, input logic [7:0] d, input logic l);
    srcq[s].push_back({l, d});
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (srcq[i].size() > 0) return 1'b1;
    return m_owner >= 0;
  endfunction

  task automatic drive();
    fifo_full     = c_full;
    overrun_clear = c_clr;
    reset_n       = c_rst;
    for (int i = 0; i < N; i++) begin
      src_valid[i] = (srcq[i].size() > 0) && !c_hold[i];
      if (srcq[i].size() > 0) begin
        src_data[i*DW +: DW] = srcq[i][0][7:0];
        src_last[i]          = srcq[i][0][8];
      end else begin
        src_data[i*DW +: DW] = DW'($urandom);
        src_last[i]          = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0]  e_rdy;
    logic          e_wen;
    logic [DW-1:0] e_wd;
    e_rdy = '0; e_wen = 1'b0; e_wd = '0;
    if (m_owner >= 0) begin
      if (!fifo_full) e_rdy[m_owner] = 1'b1;
      e_wen = src_valid[m_owner] && !fifo_full;
      if (e_wen) e_wd = srcq[m_owner][0][7:0];
    end
    chk("busy", busy, m_owner >= 0);
    chk("grant_id", grant_id, m_gid);
    chk("src_ready", src_ready, e_rdy);
    chk("write_en", fifo_write_en, e_wen);
    chk("write_data", fifo_write_data, e_wd);
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic model_edge();
    logic [N-1:0] set;
    set = '0;
    if (!reset_n) begin
      m_owner = -1; m_ptr = 0; m_gid = 0; m_cnt = 0; m_ovr = '0;
      return;
    end
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int s;
        s = (m_ptr + k) % N;
        if (src_valid[s]) begin m_owner = s; m_gid = s; break; end
      end
    end else if (src_valid[m_owner] && !fifo_full) begin
      if (src_last[m_owner] || m_cnt == MP - 1) begin
        if (!src_last[m_owner]) set[m_owner] = 1'b1;
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_cnt = 0;
      end else m_cnt++;
    end
    if (overrun_clear) m_ovr = '0;
    m_ovr |= set;
  endtask

  task automatic handshake();
    for (int i = 0; i < N; i++)
      if (src_valid[i] && src_ready[i]) void'(srcq[i].pop_front());
    if (fifo_write_en) wlog.push_back(fifo_write_data);
  endtask

  task automatic cyc();
    @(negedge clk);
    drive();
    #1;
    check_outputs();
    model_edge();
    handshake();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin cyc(); n++; end
    chk("drain_in_budget", n < budget, 1);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_len"}, wlog.size(), exq.size());
    for (int i = 0; i < exq.size() && i < wlog.size(); i++)
      chk(tag, wlog[i], exq[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1+2: reset with all sources requesting, then round-robin 2-beat packets.
    c_rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      push_beat(i, 8'h10 + 8'(i), 1'b0);
      push_beat(i, 8'h20 + 8'(i), 1'b1);
    end
    cyc(); cyc();
    c_rst = 1'b1;
    drain(100);
    exq.delete();
    for (int i = 0; i < N; i++) begin exq.push_back(8'h10 + 8'(i)); exq.push_back(8'h20 + 8'(i)); end
    check_stream("t2_order");

    // 3: backpressure during source 2's packet.
    wlog.delete(); exq.delete();
    for (int k = 0; k < 4; k++) begin push_beat(2, 8'h30 + 8'(k), k == 3); exq.push_back(8'h30 + 8'(k)); end
    cyc(); cyc();
    c_full = 1'b1; cyc(); cyc(); cyc();
    c_full = 1'b0;
    drain(50);
    check_stream("t3_order");
    chk("t3_gid", grant_id, 2);

    // 4: valid gap on source 1 with source 3 waiting.
    wlog.delete(); exq.delete();
    for (int k = 0; k < 4; k++) begin push_beat(1, 8'h40 + 8'(k), k == 3); exq.push_back(8'h40 + 8'(k)); end
    cyc();
    push_beat(3, 8'h50, 1'b0); push_beat(3, 8'h51, 1'b1);
    exq.push_back(8'h50); exq.push_back(8'h51);
    cyc();
    c_hold = 4'b0010; cyc(); cyc();
    c_hold = '0;
    drain(50);
    check_stream("t4_order");

    // 5: 20-beat packet overruns MAX_PKT.
    wlog.delete(); exq.delete();
    for (int k = 0; k < 20; k++) begin push_beat(0, 8'h60 + 8'(k), k == 19); exq.push_back(8'h60 + 8'(k)); end
    drain(80);
    check_stream("t5_order");
    chk("t5_overrun_set", overrun, 4'b0001);
    c_clr = 1'b1; cyc();
    c_clr = 1'b0; cyc();
    chk("t5_overrun_cleared", overrun, 4'b0000);

    // 6: wrap from source 3 to 0, then async reset mid-packet.
    wlog.delete(); exq.delete();
    push_beat(3, 8'h80, 1'b1);
    drain(20);
    push_beat(0, 8'h90, 1'b1); push_beat(1, 8'h91, 1'b1);
    drain(20);
    exq = '{8'h80, 8'h90, 8'h91};
    check_stream("t6_wrap");
    push_beat(0, 8'hA0, 1'b1);
    drain(20);
    for (int k = 0; k < 3; k++) push_beat(1, 8'hB0 + 8'(k), k == 2);
    cyc(); cyc();
    @(posedge clk); #2;
    reset_n = 1'b0; c_rst = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ready", src_ready, 0);
    chk("t6_rst_wen", fifo_write_en, 0);
    chk("t6_rst_wdata", fifo_write_data, 0);
    chk("t6_rst_gid", grant_id, 0);
    model_edge();
    push_beat(0, 8'hC0, 1'b1);
    cyc();
    c_rst = 1'b1;
    cyc(); cyc();
    chk("t6_gid_after_reset", grant_id, 0);
    drain(40);

    // Random traffic: packets of 1..20 beats, random full/gaps/clears.
    wlog.delete();
    pushed = 0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int s, len;
        s = $urandom_range(0, N - 1);
        len = $urandom_range(1, 20);
        if (srcq[s].size() < 25) begin
          for (int k = 0; k < len; k++) push_beat(s, 8'($urandom), k == len - 1);
          pushed += len;
        end
      end
      c_full = ($urandom_range(0, 3) == 0);
      c_hold = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      c_clr  = ($urandom_range(0, 40) == 0);
      cyc();
    end
    c_full = 1'b0; c_hold = '0; c_clr = 1'b0;
    drain(3000);
    chk("rand_beat_count", wlog.size(), pushed);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
